// File: rtl/bigint_pkg.sv
// Shared definitions for the bigint arithmetic units (add/sub, multiplier).
// Holds the default SRAM/operand widths and the sequencing state encoding.
package bigint_pkg;

  localparam int BIGINT_ADRBW = 20;  // SRAM address width
  localparam int BIGINT_WRDBW = 16;  // SRAM word width
  localparam int BIGINT_VARBW = 16;  // operand length field width (words)

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    WR   = 3'd3,
    WRC  = 3'd4,
    DONE = 3'd5
  } state_e;

endpackage

// File: rtl/bigint_addsub_unit_if.sv
// Command / SRAM bus of the bigint add/sub unit.
//   i_valid, i_op             : start pulse and operation (0 add, 1 subtract)
//   i_varsize_x1/_x2          : operand lengths in words
//   i_x1addr/_x2addr/_x3addr  : operand and result base addresses
//   i_rdata                   : SRAM read data, combinational from o_addr
//   o_wen/o_addr/o_wdata      : SRAM access
//   o_varsize_x3, o_carry     : result length, carry (add) or borrow (sub)
//   o_busy, o_done            : activity flag and one-cycle completion pulse
// slave modport is the unit side, master modport the requester/SRAM side.
interface bigint_addsub_unit_if
  import bigint_pkg::*;
#(
  parameter int ADRBW = BIGINT_ADRBW,
  parameter int WRDBW = BIGINT_WRDBW,
  parameter int VARBW = BIGINT_VARBW
) ();

  logic             i_valid;
  logic             i_op;
  logic [VARBW-1:0] i_varsize_x1;
  logic [VARBW-1:0] i_varsize_x2;
  logic [ADRBW-1:0] i_x1addr;
  logic [ADRBW-1:0] i_x2addr;
  logic [ADRBW-1:0] i_x3addr;
  logic [WRDBW-1:0] i_rdata;
  logic             o_wen;
  logic [ADRBW-1:0] o_addr;
  logic [WRDBW-1:0] o_wdata;
  logic [VARBW-1:0] o_varsize_x3;
  logic             o_carry;
  logic             o_busy;
  logic             o_done;

  modport slave (
    input  i_valid, i_op, i_varsize_x1, i_varsize_x2,
    input  i_x1addr, i_x2addr, i_x3addr, i_rdata,
    output o_wen, o_addr, o_wdata, o_varsize_x3, o_carry, o_busy, o_done
  );

  modport master (
    output i_valid, i_op, i_varsize_x1, i_varsize_x2,
    output i_x1addr, i_x2addr, i_x3addr, i_rdata,
    input  o_wen, o_addr, o_wdata, o_varsize_x3, o_carry, o_busy, o_done
  );

endinterface

// File: rtl/bigint_word_alu.sv
// One-word add/subtract with carry, purely combinational.
//   a_i, b_i  : operand words
//   sub_i     : 1 selects a + ~b + carry_i (two's complement subtract chain)
//   carry_i   : carry in (for subtract, 1 means "no borrow pending")
//   sum_o     : result word
//   carry_o   : carry out of the word
module bigint_word_alu
  import bigint_pkg::*;
#(
  parameter int WRDBW = BIGINT_WRDBW
) (
  input  logic [WRDBW-1:0] a_i,
  input  logic [WRDBW-1:0] b_i,
  input  logic             sub_i,
  input  logic             carry_i,
  output logic [WRDBW-1:0] sum_o,
  output logic             carry_o
);

  logic [WRDBW-1:0] b_eff;
  logic [WRDBW:0]   total;

  always_comb begin
    b_eff = sub_i ? ~b_i : b_i;
    total = {1'b0, a_i} + {1'b0, b_eff} + {{WRDBW{1'b0}}, carry_i};
  end

  assign sum_o   = total[WRDBW-1:0];
  assign carry_o = total[WRDBW];

endmodule

// File: rtl/bigint_addsub_unit.sv
// Multi-word add/subtract of two SRAM-resident big integers, one word per
// three cycles (read x1 word, read x2 word, write result word), with an
// extra carry word on add overflow.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : command / SRAM bus (slave side), see bigint_addsub_unit_if
// All bus outputs are registered from the current FSM state, so each state's
// SRAM access appears on the bus in the cycle after that state; read data
// for an access is therefore consumed by the following state.
module bigint_addsub_unit
  import bigint_pkg::*;
#(
  parameter int ADRBW = BIGINT_ADRBW,
  parameter int WRDBW = BIGINT_WRDBW,
  parameter int VARBW = BIGINT_VARBW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bigint_addsub_unit_if.slave  bus
);

  // Control state and registered outputs (reset)
  state_e           state_q, state_d;
  logic [VARBW-1:0] idx_q, idx_d;
  logic [VARBW-1:0] hi_q, hi_d;
  logic             hi_vld_q, hi_vld_d;
  logic             carry_q, carry_d;
  logic             o_wen_q, o_wen_d;
  logic [ADRBW-1:0] o_addr_q, o_addr_d;
  logic [WRDBW-1:0] o_wdata_q, o_wdata_d;
  logic [VARBW-1:0] o_varsize_q, o_varsize_d;
  logic             o_carry_q, o_carry_d;
  logic             o_busy_q, o_busy_d;
  logic             o_done_q, o_done_d;

  // Latched command and operand word (data only, not reset)
  logic             op_q;
  logic [VARBW-1:0] size1_q, size2_q, n_q;
  logic [ADRBW-1:0] x1_q, x2_q, x3_q;
  logic [WRDBW-1:0] a_q;

  logic             start;
  logic             cap_a;
  logic [VARBW-1:0] n_in;
  logic [WRDBW-1:0] b_word;
  logic [WRDBW-1:0] sum;
  logic             sum_carry;

  assign n_in   = (bus.i_varsize_x1 > bus.i_varsize_x2) ? bus.i_varsize_x1
                                                        : bus.i_varsize_x2;
  // Words past an operand's length read as zero.
  assign b_word = (idx_q < size2_q) ? bus.i_rdata : '0;

  bigint_word_alu #(.WRDBW(WRDBW)) u_alu (
    .a_i     (a_q),
    .b_i     (b_word),
    .sub_i   (op_q),
    .carry_i (carry_q),
    .sum_o   (sum),
    .carry_o (sum_carry)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hi_d        = hi_q;
    hi_vld_d    = hi_vld_q;
    carry_d     = carry_q;
    o_wen_d     = 1'b0;
    o_addr_d    = o_addr_q;
    o_wdata_d   = o_wdata_q;
    o_varsize_d = o_varsize_q;
    o_carry_d   = o_carry_q;
    o_done_d    = 1'b0;
    start       = 1'b0;
    cap_a       = 1'b0;

    unique case (state_q)
      IDLE: begin
        // o_busy_q stays high through the done pulse; no restart until it drops.
        if (bus.i_valid && !o_busy_q) begin
          start    = 1'b1;
          idx_d    = '0;
          hi_d     = '0;
          hi_vld_d = 1'b0;
          carry_d  = bus.i_op;  // subtract is a + ~b + 1
          state_d  = (n_in == '0) ? DONE : RD1;
        end
      end
      RD1: begin
        o_addr_d = x1_q + ADRBW'(idx_q);
        state_d  = RD2;
      end
      RD2: begin
        o_addr_d = x2_q + ADRBW'(idx_q);
        cap_a    = 1'b1;  // bus currently shows the x1 word
        state_d  = WR;
      end
      WR: begin
        // bus currently shows the x2 word; the ALU sees it via b_word
        o_wen_d   = 1'b1;
        o_addr_d  = x3_q + ADRBW'(idx_q);
        o_wdata_d = sum;
        carry_d   = sum_carry;
        if (sum != '0) begin
          hi_d     = idx_q;
          hi_vld_d = 1'b1;
        end
        idx_d = idx_q + 1'b1;
        if (idx_d < n_q)              state_d = RD1;
        else if (!op_q && sum_carry)  state_d = WRC;
        else                          state_d = DONE;
      end
      WRC: begin
        o_wen_d   = 1'b1;
        o_addr_d  = x3_q + ADRBW'(n_q);
        o_wdata_d = {{(WRDBW-1){1'b0}}, 1'b1};
        hi_d      = n_q;
        hi_vld_d  = 1'b1;
        state_d   = DONE;
      end
      DONE: begin
        o_done_d    = 1'b1;
        o_varsize_d = hi_vld_q ? (hi_q + 1'b1) : '0;
        // Final subtract carry of 0 means the chain borrowed (x1 < x2).
        o_carry_d   = op_q ? ~carry_q : carry_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    o_busy_d = (state_d != IDLE) || (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hi_q        <= '0;
      hi_vld_q    <= 1'b0;
      carry_q     <= 1'b0;
      o_wen_q     <= 1'b0;
      o_addr_q    <= '0;
      o_wdata_q   <= '0;
      o_varsize_q <= '0;
      o_carry_q   <= 1'b0;
      o_busy_q    <= 1'b0;
      o_done_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hi_q        <= hi_d;
      hi_vld_q    <= hi_vld_d;
      carry_q     <= carry_d;
      o_wen_q     <= o_wen_d;
      o_addr_q    <= o_addr_d;
      o_wdata_q   <= o_wdata_d;
      o_varsize_q <= o_varsize_d;
      o_carry_q   <= o_carry_d;
      o_busy_q    <= o_busy_d;
      o_done_q    <= o_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      op_q    <= bus.i_op;
      size1_q <= bus.i_varsize_x1;
      size2_q <= bus.i_varsize_x2;
      n_q     <= n_in;
      x1_q    <= bus.i_x1addr;
      x2_q    <= bus.i_x2addr;
      x3_q    <= bus.i_x3addr;
    end
    if (cap_a) begin
      a_q <= (idx_q < size1_q) ? bus.i_rdata : '0;
    end
  end

  assign bus.o_wen        = o_wen_q;
  assign bus.o_addr       = o_addr_q;
  assign bus.o_wdata      = o_wdata_q;
  assign bus.o_varsize_x3 = o_varsize_q;
  assign bus.o_carry      = o_carry_q;
  assign bus.o_busy       = o_busy_q;
  assign bus.o_done       = o_done_q;

endmodule

// File: tb/tb_bigint_addsub_unit.sv
// Directed bench for bigint_addsub_unit with a big-integer reference model.
module tb_bigint_addsub_unit;
  import bigint_pkg::*;

  localparam int ADRBW = BIGINT_ADRBW;
  localparam int WRDBW = BIGINT_WRDBW;
  localparam int VARBW = BIGINT_VARBW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  bigint_addsub_unit_if #(.ADRBW(ADRBW), .WRDBW(WRDBW), .VARBW(VARBW)) bus ();

  bigint_addsub_unit #(.ADRBW(ADRBW), .WRDBW(WRDBW), .VARBW(VARBW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 64-word SRAM model; init_mem is the image copied in before each run.
  logic [15:0] mem      [64];
  logic [15:0] init_mem [64];
  logic        load_mem = 1'b0;

  assign bus.i_rdata = mem[bus.o_addr[5:0]];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int j = 0; j < 64; j++) mem[j] <= init_mem[j];
    end else if (bus.o_wen) begin
      mem[bus.o_addr[5:0]] <= bus.o_wdata;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one operation, checking every bus cycle against the model.
  task automatic run_op(input string tag, input bit op, input int s1, input int s2,
                        input int a1, input int a2, input int a3, input bit poke,
                        output int done_cyc, output int vs_out, output int cy_out);
    longint unsigned x1v, x2v, m, tot, r;
    bit              cy, got;
    int              n, nwr, vs, cyc, k, wi, mism;
    logic [15:0]     w    [4];
    logic [15:0]     expm [64];

    // Reference: whole-number arithmetic on the operand values.
    x1v = 0;
    x2v = 0;
    for (int i = 0; i < s1; i++) x1v |= 64'(init_mem[(a1 + i) % 64]) << (16 * i);
    for (int i = 0; i < s2; i++) x2v |= 64'(init_mem[(a2 + i) % 64]) << (16 * i);
    n = (s1 > s2) ? s1 : s2;
    m = (n == 0) ? 64'd0 : ((64'd1 << (16 * n)) - 64'd1);
    if (!op) begin
      tot = x1v + x2v;
      r   = tot & m;
      cy  = (n != 0) && (((tot >> (16 * n)) & 64'd1) != 0);
    end else begin
      r  = (x1v - x2v) & m;
      cy = (x1v < x2v);
    end
    nwr = n + ((!op && cy) ? 1 : 0);
    for (int i = 0; i < 4; i++)
      w[i] = (i < n) ? 16'(r >> (16 * i)) : ((i == n && !op && cy) ? 16'd1 : 16'd0);
    vs = 0;
    for (int i = 0; i < nwr; i++) if (w[i] != 16'd0) vs = i + 1;
    cyc = 3 * n + 2 + ((!op && cy) ? 1 : 0);
    for (int j = 0; j < 64; j++) expm[j] = init_mem[j];
    for (int i = 0; i < nwr; i++) expm[(a3 + i) % 64] = w[i];

    @(negedge clk) load_mem = 1'b1;
    @(negedge clk) load_mem = 1'b0;
    bus.i_op         = op;
    bus.i_varsize_x1 = VARBW'(s1);
    bus.i_varsize_x2 = VARBW'(s2);
    bus.i_x1addr     = ADRBW'(a1);
    bus.i_x2addr     = ADRBW'(a2);
    bus.i_x3addr     = ADRBW'(a3);
    bus.i_valid      = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    chk({tag, "_busy_after_start"}, bus.o_busy, 1);

    k = 0; wi = 0; got = 0;
    done_cyc = 0; vs_out = 0; cy_out = 0;
    while (!got && k < 200) begin
      if (k == 2) begin
        // inputs are latched at start; disturbing them must not matter
        bus.i_op         = ~op;
        bus.i_x3addr     = ADRBW'(50);
        bus.i_varsize_x1 = VARBW'(7);
      end
      if (poke) bus.i_valid = (k == 3);
      @(negedge clk);
      k++;
      if (bus.o_wen) begin
        if (wi < nwr) begin
          chk($sformatf("%s_wr%0d_addr", tag, wi), bus.o_addr, ADRBW'(a3 + wi));
          chk($sformatf("%s_wr%0d_data", tag, wi), bus.o_wdata, w[wi]);
        end
        wi++;
      end
      if (bus.o_done) begin
        got      = 1'b1;
        done_cyc = k + 1;
        vs_out   = int'(bus.o_varsize_x3);
        cy_out   = int'(bus.o_carry);
        chk({tag, "_cycles"}, done_cyc, cyc);
        chk({tag, "_varsize"}, bus.o_varsize_x3, vs);
        chk({tag, "_carry"}, bus.o_carry, cy);
        chk({tag, "_busy_at_done"}, bus.o_busy, 1);
      end else begin
        chk({tag, "_busy"}, bus.o_busy, 1);
      end
    end
    bus.i_valid = 1'b0;
    chk({tag, "_done_seen"}, got, 1);
    chk({tag, "_write_count"}, wi, nwr);

    @(negedge clk);
    chk({tag, "_done_one_cycle"}, bus.o_done, 0);
    chk({tag, "_busy_released"}, bus.o_busy, 0);
    chk({tag, "_varsize_hold"}, bus.o_varsize_x3, vs);
    chk({tag, "_carry_hold"}, bus.o_carry, cy);
    mism = 0;
    for (int j = 0; j < 64; j++) if (mem[j] !== expm[j]) mism++;
    chk({tag, "_mem_words_wrong"}, mism, 0);
  endtask

  int dc, vo, co, k, wens;
  bit found;

  initial begin
    bus.i_valid      = 1'b0;
    bus.i_op         = 1'b0;
    bus.i_varsize_x1 = '0;
    bus.i_varsize_x2 = '0;
    bus.i_x1addr     = '0;
    bus.i_x2addr     = '0;
    bus.i_x3addr     = '0;

    for (int j = 0; j < 64; j++) init_mem[j] = 16'h5a00 | 16'(j);
    // REQ-029/030/034 operands
    init_mem[0] = 16'ha836; init_mem[1] = 16'h5cb4; init_mem[2] = 16'h000b;
    init_mem[3] = 16'h0fcb; init_mem[4] = 16'h334f; init_mem[5] = 16'hdeac;
    // single-word overflow
    init_mem[10] = 16'hffff; init_mem[12] = 16'h0001;
    // equal subtract
    init_mem[16] = 16'h1234; init_mem[17] = 16'h5678;
    init_mem[20] = 16'h1234; init_mem[21] = 16'h5678;
    // unequal lengths
    init_mem[28] = 16'h0001; init_mem[29] = 16'h0002; init_mem[30] = 16'h0003;
    init_mem[32] = 16'hffff; init_mem[33] = 16'h7777; init_mem[34] = 16'h8888;
    // short minuend, long subtrahend
    init_mem[44] = 16'h0005;
    init_mem[46] = 16'h0003; init_mem[47] = 16'h0001;

    repeat (3) @(negedge clk);
    chk("reset_wen", bus.o_wen, 0);
    chk("reset_addr", bus.o_addr, 0);
    chk("reset_wdata", bus.o_wdata, 0);
    chk("reset_varsize", bus.o_varsize_x3, 0);
    chk("reset_carry", bus.o_carry, 0);
    chk("reset_busy", bus.o_busy, 0);
    chk("reset_done", bus.o_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add3", 1'b0, 3, 3, 0, 3, 6, 1'b0, dc, vo, co);
    chk("add3_lit_w0", mem[6], 16'hb801);
    chk("add3_lit_w1", mem[7], 16'h9003);
    chk("add3_lit_w2", mem[8], 16'hdeb7);
    chk("add3_lit_cycle", dc, 11);
    chk("add3_lit_vs", vo, 3);
    chk("add3_lit_carry", co, 0);

    run_op("sub3", 1'b1, 3, 3, 0, 3, 6, 1'b1, dc, vo, co);
    chk("sub3_lit_w0", mem[6], 16'h986b);
    chk("sub3_lit_w1", mem[7], 16'h2965);
    chk("sub3_lit_w2", mem[8], 16'h215f);
    chk("sub3_lit_vs", vo, 3);
    chk("sub3_lit_borrow", co, 1);

    run_op("addwrc", 1'b0, 1, 1, 10, 12, 14, 1'b0, dc, vo, co);
    chk("addwrc_lit_w0", mem[14], 16'h0000);
    chk("addwrc_lit_w1", mem[15], 16'h0001);
    chk("addwrc_lit_vs", vo, 2);
    chk("addwrc_lit_cycle", dc, 6);

    run_op("subeq", 1'b1, 2, 2, 16, 20, 24, 1'b0, dc, vo, co);
    chk("subeq_lit_w0", mem[24], 16'h0000);
    chk("subeq_lit_w1", mem[25], 16'h0000);
    chk("subeq_lit_vs", vo, 0);
    chk("subeq_lit_carry", co, 0);

    run_op("addlen", 1'b0, 3, 1, 28, 32, 36, 1'b0, dc, vo, co);
    chk("addlen_lit_w0", mem[36], 16'h0000);
    chk("addlen_lit_w1", mem[37], 16'h0003);
    chk("addlen_lit_w2", mem[38], 16'h0003);
    chk("addlen_lit_vs", vo, 3);

    run_op("sublen", 1'b1, 1, 2, 44, 46, 48, 1'b0, dc, vo, co);
    chk("sublen_lit_w0", mem[48], 16'h0002);
    chk("sublen_lit_w1", mem[49], 16'hffff);
    chk("sublen_lit_borrow", co, 1);

    run_op("empty", 1'b1, 0, 0, 0, 3, 40, 1'b0, dc, vo, co);
    chk("empty_lit_cycle", dc, 2);
    chk("empty_lit_vs", vo, 0);

    // Reset while the x2 word 1 read is on the bus.
    @(negedge clk) load_mem = 1'b1;
    @(negedge clk) load_mem = 1'b0;
    bus.i_op = 1'b1; bus.i_varsize_x1 = 3; bus.i_varsize_x2 = 3;
    bus.i_x1addr = 0; bus.i_x2addr = 3; bus.i_x3addr = 6;
    bus.i_valid = 1'b1;
    @(negedge clk);
    bus.i_valid = 1'b0;
    k = 0; found = 0;
    while (!found && k < 100) begin
      @(negedge clk);
      k++;
      if (bus.o_addr == ADRBW'(4) && !bus.o_wen) found = 1'b1;
    end
    chk("rst_trigger_seen", found, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_wen", bus.o_wen, 0);
    chk("rst_mid_addr", bus.o_addr, 0);
    chk("rst_mid_wdata", bus.o_wdata, 0);
    chk("rst_mid_varsize", bus.o_varsize_x3, 0);
    chk("rst_mid_carry", bus.o_carry, 0);
    chk("rst_mid_busy", bus.o_busy, 0);
    chk("rst_mid_done", bus.o_done, 0);
    rst_n = 1'b1;
    wens = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.o_wen) wens++;
    end
    chk("rst_no_more_writes", wens, 0);
    chk("rst_idle_busy", bus.o_busy, 0);
    chk("rst_word0_written", mem[6], 16'h986b);
    chk("rst_word1_untouched", mem[7], init_mem[7]);

    run_op("inplace", 1'b0, 3, 3, 0, 3, 0, 1'b0, dc, vo, co);
    chk("inplace_lit_w0", mem[0], 16'hb801);
    chk("inplace_lit_w1", mem[1], 16'h9003);
    chk("inplace_lit_w2", mem[2], 16'hdeb7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bigint_addsub_unit.md
BIGINT_ADDSUB_UNIT -- requirements
Module: bigint_addsub_unit

Interface
REQ-001 SHALL have parameter ADRBW, default 20, SRAM address width.
REQ-002 SHALL have parameter WRDBW, default 16, SRAM word width.
REQ-003 SHALL have parameter VARBW, default 16, operand size field width (in words).
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_valid  input  1  start pulse; sampled only in IDLE.
REQ-007 SHALL have port i_op  input  1  0 = add (x1+x2), 1 = subtract (x1-x2); latched at start.
REQ-008 SHALL have ports i_varsize_x1, i_varsize_x2  input  VARBW  operand lengths in words; latched at start.
REQ-009 SHALL have ports i_x1addr, i_x2addr, i_x3addr  input  ADRBW  operand/result base addresses, word 0 least significant; latched at start.
REQ-010 SHALL have port i_rdata  input  WRDBW  SRAM read data, combinational from o_addr in the same cycle.
REQ-011 SHALL have ports o_wen (1), o_addr (ADRBW), o_wdata (WRDBW)  output  SRAM write enable, address, write data.
REQ-012 SHALL have ports o_varsize_x3 (VARBW), o_carry (1), o_busy (1), o_done (1)  output  result length, carry/borrow out, busy, one-cycle completion pulse.

Function
REQ-013 SHALL use FSM states IDLE, RD1, RD2, WR, WRC, DONE; all outputs registered.
REQ-014 SHALL, in IDLE with i_valid=1, latch all inputs, set n = max(size_x1, size_x2), index i=0, carry=op, and go to RD1, or to DONE if n=0.
REQ-015 SHALL, in RD1, drive o_addr = x1addr+i and capture a = (i<size_x1) ? i_rdata : 0.
REQ-016 SHALL, in RD2, drive o_addr = x2addr+i, capture b = (i<size_x2) ? i_rdata : 0, and compute {c', r} = a + (op ? ~b : b) + carry in WRDBW+1 bits.
REQ-017 SHALL, in WR, assert o_wen=1 for exactly one cycle with o_addr = x3addr+i and o_wdata = r, update carry = c', and record i as highest-nonzero index if r != 0.
REQ-018 SHALL, after WR, increment i and go to RD1 if i<n; otherwise go to WRC if op=add and carry=1, else to DONE.
REQ-019 SHALL, in WRC, write word 1 at x3addr+n and record n as highest-nonzero index.
REQ-020 SHALL, in DONE, assert o_done=1 for one cycle, present o_varsize_x3 = highest-nonzero index+1 (0 if all result words zero), and o_carry = add carry out, or for subtract 1 = borrow (x1<x2, result = x1-x2 mod 2^(WRDBW*n)); return to IDLE.
REQ-021 SHALL hold o_varsize_x3 and o_carry stable from DONE until the next accepted start.
REQ-022 SHALL take exactly 3n+2 cycles (3n+3 with WRC) from the accepting edge to the end of the o_done cycle.
REQ-023 SHALL ignore i_valid whenever not in IDLE; o_busy=1 in every state except IDLE.
REQ-024 SHALL support in-place operation when x3addr <= x1addr and x3addr <= x2addr, since word i is written only after both word-i reads.
REQ-025 SHALL compute all address arithmetic modulo 2^ADRBW.

Reset
REQ-026 SHALL, on rst_n low at any time including mid-operation, go to IDLE and drive o_wen=0, o_addr=0, o_wdata=0, o_varsize_x3=0, o_carry=0, o_busy=0, o_done=0; no partial write completes after reset.

Structure
REQ-027 SHALL place the FSM state enum and default widths in shared package bigint_pkg, also used by the multiplier unit.
REQ-028 SHALL implement the one-word add/sub with carry as combinational sub-module bigint_word_alu; everything else lives in bigint_addsub_unit.

Verification
REQ-029 SHALL check add of x1=[a836,5cb4,000b] @0 and x2=[0fcb,334f,deac] @3 into 6 -> SRAM[6..8]=[b801,9003,deb7], varsize 3, carry 0, done at cycle 11.
REQ-030 SHALL check subtract of the same operands -> [986b,2965,215f], varsize 3, o_carry=1 (borrow).
REQ-031 SHALL check add x1=[ffff], x2=[0001] -> [0000,0001], WRC write at x3addr+1, varsize 2, done at cycle 6.
REQ-032 SHALL check subtract x1=x2=[1234,5678] -> [0000,0000], varsize 0, carry 0; and size_x1=3, size_x2=1 with x2 words beyond index 0 treated as zero.
REQ-033 SHALL check rst_n asserted during RD2 of word 1 -> all outputs 0 next cycle, no further o_wen; i_valid pulsed while busy -> ignored.
REQ-034 SHALL check in-place add with x3addr=x1addr -> same result as the out-of-place run.
